// File: rtl/l2_axi_master.sv
// L2-side AXI-lite initiator: single-beat reads, posted writes through a
// coalescing FIFO with read forwarding, one AXI transaction in flight at a time.
module l2_axi_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int WB_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  wbuf_empty_o,
    output logic [ADDR_WIDTH-1:0] m_araddr_o,
    output logic                  m_arvalid_o,
    input  logic                  m_arready_i,
    input  logic [DATA_WIDTH-1:0] m_rdata_i,
    input  logic                  m_rvalid_i,
    output logic                  m_rready_o,
    output logic [ADDR_WIDTH-1:0] m_awaddr_o,
    output logic                  m_awvalid_o,
    input  logic                  m_awready_i,
    output logic [DATA_WIDTH-1:0] m_wdata_o,
    output logic                  m_wvalid_o,
    input  logic                  m_wready_i,
    input  logic                  m_bvalid_i,
    output logic                  m_bready_o
);
    localparam int PTR_W = $clog2(WB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [2:0] A_IDLE = 3'd0;
    localparam logic [2:0] A_AR   = 3'd1;
    localparam logic [2:0] A_R    = 3'd2;
    localparam logic [2:0] A_W    = 3'd3;
    localparam logic [2:0] A_B    = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  rd_busy_q, rd_busy_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic                  arvalid_q, arvalid_d, rready_q, rready_d;
    logic                  awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d, awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    logic [ADDR_WIDTH-1:0] wb_addr_q [WB_DEPTH];
    logic [DATA_WIDTH-1:0] wb_data_q [WB_DEPTH];

    logic                  req_accept, wr_acc, rd_acc, push, pop, head_locked;
    logic                  fwd_hit, co_hit;
    logic [DATA_WIDTH-1:0] fwd_data;
    logic [PTR_W-1:0]      co_idx;
    logic [PTR_W-1:0]      slot_idx [WB_DEPTH];
    logic [WB_DEPTH-1:0]   slot_hit;

    assign req_ready_o = !rd_busy_q && (count_q < CNT_W'(WB_DEPTH));
    assign req_accept  = req_valid_i && req_ready_o;
    assign wr_acc      = req_accept && req_we_i;
    assign rd_acc      = req_accept && !req_we_i;

    // Slot gi is the gi-th oldest entry; it is live only while gi < count.
    for (genvar gi = 0; gi < WB_DEPTH; gi++) begin : g_slot
        assign slot_idx[gi] = head_q + PTR_W'(gi);
        assign slot_hit[gi] = (CNT_W'(gi) < count_q) && (wb_addr_q[slot_idx[gi]] == req_addr_i);
    end

    // The head is frozen once it is being (or about to be) loaded into AW/W.
    assign head_locked = (state_q == A_W) || (state_q == A_B) ||
                         ((state_q == A_IDLE) && !rd_busy_q && (count_q != '0));

    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        co_hit   = 1'b0;
        co_idx   = '0;
        for (int k = 0; k < WB_DEPTH; k++) begin
            if (slot_hit[k]) begin
                fwd_hit  = 1'b1;
                fwd_data = wb_data_q[slot_idx[k]];
                if (!((k == 0) && head_locked)) begin
                    co_hit = 1'b1;
                    co_idx = slot_idx[k];
                end
            end
        end
    end

    assign push = wr_acc && !co_hit;

    always_comb begin
        state_d     = state_q;
        rd_busy_d   = rd_busy_q;
        rd_addr_d   = rd_addr_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        arvalid_d   = arvalid_q;
        araddr_d    = araddr_q;
        rready_d    = rready_q;
        awvalid_d   = awvalid_q;
        awaddr_d    = awaddr_q;
        wvalid_d    = wvalid_q;
        wdata_d     = wdata_q;
        bready_d    = bready_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        pop         = 1'b0;

        if (rd_acc) begin
            if (fwd_hit) begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = fwd_data;
            end else begin
                rd_busy_d = 1'b1;
                rd_addr_d = req_addr_i;
            end
        end

        case (state_q)
            A_IDLE: begin
                if (rd_busy_q) begin
                    state_d   = A_AR;
                    arvalid_d = 1'b1;
                    araddr_d  = rd_addr_q;
                end else if (count_q != '0) begin
                    state_d   = A_W;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    awaddr_d  = wb_addr_q[head_q];
                    wdata_d   = wb_data_q[head_q];
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            A_AR: begin
                if (m_arready_i) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = A_R;
                end
            end
            A_R: begin
                if (m_rvalid_i) begin
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = m_rdata_i;
                    rd_busy_d   = 1'b0;
                    state_d     = A_IDLE;
                end
            end
            A_W: begin
                if (awvalid_q && m_awready_i) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (wvalid_q && m_wready_i) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (aw_done_d && w_done_d) begin
                    bready_d = 1'b1;
                    state_d  = A_B;
                end
            end
            A_B: begin
                if (m_bvalid_i) begin
                    bready_d = 1'b0;
                    pop      = 1'b1;
                    state_d  = A_IDLE;
                end
            end
            default: state_d = A_IDLE;
        endcase

        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        head_d  = head_q + PTR_W'(pop);
        tail_d  = tail_q + PTR_W'(push);
    end

    // Entry storage carries no reset; liveness is tracked by head/count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            wb_addr_q[tail_q] <= req_addr_i;
            wb_data_q[tail_q] <= req_wdata_i;
        end else if (wr_acc && co_hit) begin
            wb_data_q[co_idx] <= req_wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= A_IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            rd_busy_q   <= 1'b0;
            rd_addr_q   <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            araddr_q    <= '0;
            rready_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            awaddr_q    <= '0;
            wvalid_q    <= 1'b0;
            wdata_q     <= '0;
            bready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            rd_busy_q   <= rd_busy_d;
            rd_addr_q   <= rd_addr_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            arvalid_q   <= arvalid_d;
            araddr_q    <= araddr_d;
            rready_q    <= rready_d;
            awvalid_q   <= awvalid_d;
            awaddr_q    <= awaddr_d;
            wvalid_q    <= wvalid_d;
            wdata_q     <= wdata_d;
            bready_q    <= bready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_rdata_o  = rsp_rdata_q;
    assign wbuf_empty_o = (count_q == '0);
    assign m_araddr_o   = araddr_q;
    assign m_arvalid_o  = arvalid_q;
    assign m_rready_o   = rready_q;
    assign m_awaddr_o   = awaddr_q;
    assign m_awvalid_o  = awvalid_q;
    assign m_wdata_o    = wdata_q;
    assign m_wvalid_o   = wvalid_q;
    assign m_bready_o   = bready_q;
endmodule
